procyon_run_ctrl: RTL
=====================

// Module: procyon_run_ctrl
// PURPOSE
//  Run-control and retire-trace unit for FPGA bring-up of the procyon core. Gates the core via a clock
//  enable (no gated clocks), halts on single-step, N-step, breakpoint or external request, resumes on
//  pulse. Captures retirements into a FWFT trace FIFO and muxes a debug value to the display decoders.
// PARAMETERS
//  OPTN_DATA_WIDTH       32  retire data / retire-counter width
//  OPTN_ADDR_WIDTH       32  redirect / breakpoint address width
//  OPTN_REGMAP_IDX_WIDTH 5   rdest index width
//  OPTN_STEP_CNT_WIDTH   8   N-step counter width
//  OPTN_TRACE_DEPTH      8   trace FIFO entries, power of 2, >=2
// PORTS
//  clk                   in   1      clock
//  n_rst                 in   1      async active-low reset
//  i_mode                in   2      00 free, 01 single-step, 10 N-step, 11 breakpoint
//  i_step_count          in   STEP   N for mode 10 (0 treated as 1)
//  i_bp_addr             in   ADDR   breakpoint address for mode 11
//  i_resume              in   1      single-cycle resume pulse (already synchronised)
//  i_halt_req            in   1      level halt request, any mode
//  i_retire_en           in   1      core retire valid
//  i_retire_rdest        in   IDX    retired destination register
//  i_retire_data         in   DATA   retired value
//  i_redirect            in   1      ROB redirect valid
//  i_redirect_addr       in   ADDR   redirect target
//  o_core_en             out  1      core/wishbone clock enable
//  o_halted              out  1      state==HALT
//  i_trace_pop           in   1      pop trace head
//  i_trace_clr           in   1      flush FIFO, clear overflow
//  o_trace_valid         out  1      FIFO non-empty
//  o_trace_rdest         out  IDX    head rdest
//  o_trace_data          out  DATA   head data
//  o_trace_count         out  clog2(DEPTH)+1  occupancy
//  o_trace_overflow      out  1      sticky: retire dropped while full
//  i_disp_sel            in   2      00 last retire data, 01 last redirect addr, 10 trace head, 11 retire count
//  o_disp_value          out  DATA   registered display value (addr zero-extended/truncated to DATA)
// BEHAVIOUR
//  Reset: state HALT, o_core_en=0, o_halted=1, FIFO empty, count 0, overflow 0, step counter 0,
//   retire counter 0, last-retire/last-redirect 0, o_disp_value 0.
//  States RUN/HALT only. o_core_en registered = (next state==RUN); core inputs are qualified by
//   o_core_en: retire/redirect seen while o_core_en=0 are ignored entirely.
//  RUN->HALT at next edge when any of: i_halt_req; mode 01 & retire; mode 10 & retire & cnt==1;
//   mode 11 & redirect & addr==i_bp_addr. The triggering retire is recorded; exactly one retire per
//   step in mode 01, exactly N in mode 10.
//  HALT->RUN on i_resume & ~i_halt_req; step counter loads max(i_step_count,1) same edge. Mode 10
//   decrements per qualified retire while RUN. i_resume in RUN ignored; halt beats resume in RUN.
//  i_mode sampled every cycle; changing mode in RUN takes effect next cycle, counter not reloaded.
//  Retire counter +1 per qualified retire, wraps at 2^DATA.
//  FIFO push = qualified retire; pop = i_trace_pop & o_trace_valid (pop when empty ignored).
//   Full & push & ~pop: entry dropped, overflow set. Full & push & pop: both occur, no overflow.
//   i_trace_clr wins over push/pop same cycle: empty, overflow 0. Pointers wrap mod DEPTH.
//  o_disp_value: 1-cycle latency from i_disp_sel/source change; trace-head select shows 0 when empty.
//  n_rst mid-run: immediate async return to reset values, FIFO contents discarded.
// TESTING
//  T1 reset, mode 01, resume; retires 0x11,0x22 on consecutive cycles -> halts after 0x11, count=1,
//   second retire not accepted until next resume.
//  T2 mode 10, step_count=3, resume, 5 retires offered -> exactly 3 recorded, o_halted=1, retire
//   counter=3; step_count=0 -> exactly 1.
//  T3 mode 11, bp=0x100; redirects 0x80 then 0x100 -> RUN after 0x80, HALT edge after 0x100,
//   disp_sel=01 shows 0x100.
//  T4 mode 00, 9 retires, DEPTH 8 no pops -> count=8, overflow=1, head=first retire; push+pop when
//   full -> count stays 8, overflow unchanged; trace_clr -> count 0, overflow 0.
//  T5 halt_req and resume same cycle in HALT -> stays HALT; in RUN -> HALT next edge.
//  T6 n_rst low mid-N-step with 4 entries queued -> all outputs reset values same cycle, FIFO empty.

Source files
------------

// File: rtl/procyon_run_ctrl.sv
// procyon_run_ctrl: run/halt control with clock-enable gating, retire trace FIFO and debug display mux.
// Core activity is only honoured while o_core_en is high, so a halted core cannot change any state here.
module procyon_run_ctrl #(
    parameter int OPTN_DATA_WIDTH       = 32,
    parameter int OPTN_ADDR_WIDTH       = 32,
    parameter int OPTN_REGMAP_IDX_WIDTH = 5,
    parameter int OPTN_STEP_CNT_WIDTH   = 8,
    parameter int OPTN_TRACE_DEPTH      = 8
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic [1:0]                          i_mode,
    input  logic [OPTN_STEP_CNT_WIDTH-1:0]      i_step_count,
    input  logic [OPTN_ADDR_WIDTH-1:0]          i_bp_addr,
    input  logic                                i_resume,
    input  logic                                i_halt_req,
    input  logic                                i_retire_en,
    input  logic [OPTN_REGMAP_IDX_WIDTH-1:0]    i_retire_rdest,
    input  logic [OPTN_DATA_WIDTH-1:0]          i_retire_data,
    input  logic                                i_redirect,
    input  logic [OPTN_ADDR_WIDTH-1:0]          i_redirect_addr,
    output logic                                o_core_en,
    output logic                                o_halted,
    input  logic                                i_trace_pop,
    input  logic                                i_trace_clr,
    output logic                                o_trace_valid,
    output logic [OPTN_REGMAP_IDX_WIDTH-1:0]    o_trace_rdest,
    output logic [OPTN_DATA_WIDTH-1:0]          o_trace_data,
    output logic [$clog2(OPTN_TRACE_DEPTH):0]   o_trace_count,
    output logic                                o_trace_overflow,
    input  logic [1:0]                          i_disp_sel,
    output logic [OPTN_DATA_WIDTH-1:0]          o_disp_value
);
    localparam int AW = $clog2(OPTN_TRACE_DEPTH);
    localparam logic [OPTN_STEP_CNT_WIDTH-1:0] STEP_ONE = 1;

    typedef enum logic {HALT, RUN} state_t;
    state_t state, state_nxt;

    logic                               retire, redirect, stop, push, pop, full;
    logic [OPTN_STEP_CNT_WIDTH-1:0]     step_cnt, step_nxt;
    logic [AW:0]                        wr_ptr, rd_ptr;
    logic [OPTN_DATA_WIDTH-1:0]         mem_data [OPTN_TRACE_DEPTH];
    logic [OPTN_REGMAP_IDX_WIDTH-1:0]   mem_rdest [OPTN_TRACE_DEPTH];
    logic [OPTN_DATA_WIDTH-1:0]         retire_cnt, last_data, disp_nxt;
    logic [OPTN_ADDR_WIDTH-1:0]         last_redirect;

    assign retire   = i_retire_en & o_core_en;
    assign redirect = i_redirect & o_core_en;
    assign o_halted = (state == HALT);

    always_comb begin
        stop = i_halt_req
             | (i_mode == 2'b01 & retire)
             | (i_mode == 2'b10 & retire & step_cnt == STEP_ONE)
             | (i_mode == 2'b11 & redirect & i_redirect_addr == i_bp_addr);
        state_nxt = state;
        step_nxt  = step_cnt;
        if (state == HALT) begin
            if (i_resume & ~i_halt_req) begin
                state_nxt = RUN;
                step_nxt  = (i_step_count == '0) ? STEP_ONE : i_step_count;
            end
        end else begin
            if (stop)
                state_nxt = HALT;
            // a counter already at zero (mode switched mid-run) must not wrap
            if (i_mode == 2'b10 && retire && step_cnt != '0)
                step_nxt = step_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= HALT;
            o_core_en     <= 1'b0;
            step_cnt      <= '0;
            retire_cnt    <= '0;
            last_data     <= '0;
            last_redirect <= '0;
            o_disp_value  <= '0;
        end else begin
            state        <= state_nxt;
            o_core_en    <= (state_nxt == RUN);
            step_cnt     <= step_nxt;
            o_disp_value <= disp_nxt;
            if (retire) begin
                retire_cnt <= retire_cnt + 1'b1;
                last_data  <= i_retire_data;
            end
            if (redirect)
                last_redirect <= i_redirect_addr;
        end
    end

    assign o_trace_valid = (wr_ptr != rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop           = i_trace_pop & o_trace_valid;
    assign push          = retire & (~full | pop);
    assign o_trace_count = wr_ptr - rd_ptr;
    assign o_trace_data  = o_trace_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
    assign o_trace_rdest = o_trace_valid ? mem_rdest[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_trace_overflow <= 1'b0;
        end else if (i_trace_clr) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_trace_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (retire & full & ~pop)
                o_trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~i_trace_clr) begin
            mem_data[wr_ptr[AW-1:0]]  <= i_retire_data;
            mem_rdest[wr_ptr[AW-1:0]] <= i_retire_rdest;
        end
    end

    always_comb
        disp_nxt = (i_disp_sel == 2'b00) ? last_data :
                   (i_disp_sel == 2'b01) ? OPTN_DATA_WIDTH'(last_redirect) :
                   (i_disp_sel == 2'b10) ? o_trace_data : retire_cnt;
endmodule
